// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
//   Shared constants for the multicycle ALU controller: opcode / opext
//   encodings, ALU control words, FSM state type and a small helper that maps
//   an instruction code onto its ALU control word.
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

   // op = OP_REG selects the register forms; the function code is in opext.
   // Every other legal op is an immediate form that reuses the same codes.
   localparam logic [3:0] OP_REG   = 4'h0;
   localparam logic [3:0] CODE_AND = 4'h1;
   localparam logic [3:0] CODE_OR  = 4'h2;
   localparam logic [3:0] CODE_ADD = 4'h5;
   localparam logic [3:0] CODE_SUB = 4'h9;
   localparam logic [3:0] CODE_SLT = 4'hB;

   // alucont[2] inverts b and sets carry-in; [1:0] selects the result.
   localparam logic [2:0] ALUCONT_AND = 3'b000;
   localparam logic [2:0] ALUCONT_OR  = 3'b001;
   localparam logic [2:0] ALUCONT_ADD = 3'b010;
   localparam logic [2:0] ALUCONT_SUB = 3'b110;
   localparam logic [2:0] ALUCONT_SLT = 3'b111;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DECODE    = 2'd1,
      EXECUTE   = 2'd2,
      WRITEBACK = 2'd3
   } state_t;

   // Maps a function code onto {legal, alucont}. Unknown codes return
   // legal = 0 with alucont = AND so the control word is never X.
   function automatic logic [3:0] code_to_alucont(input logic [3:0] code);
      logic [3:0] res;
      case (code)
         CODE_AND: res = {1'b1, ALUCONT_AND};
         CODE_OR:  res = {1'b1, ALUCONT_OR};
         CODE_ADD: res = {1'b1, ALUCONT_ADD};
         CODE_SUB: res = {1'b1, ALUCONT_SUB};
         CODE_SLT: res = {1'b1, ALUCONT_SLT};
         default:  res = {1'b0, ALUCONT_AND};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/alu_decode.sv
// ---------------------------------------------------------------------------
// alu_decode
//   Purely combinational instruction decoder. Takes the opcode, opext and
//   low byte of the instruction register and produces the ALU control word,
//   the b-operand select, the extended immediate and a legality flag.
// Ports
//   i_op         op field   [15:12]
//   i_opext      opext field [7:4]
//   i_imm8       immediate field [7:0]
//   o_alucont    ALU control word
//   o_alusrc_imm 1 = b operand is the immediate
//   o_imm        immediate extended to WIDTH
//   o_legal      encoding is defined
// ---------------------------------------------------------------------------
module alu_decode
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [3:0]       i_op,
   input  logic [3:0]       i_opext,
   input  logic [7:0]       i_imm8,
   output logic [2:0]       o_alucont,
   output logic             o_alusrc_imm,
   output logic [WIDTH-1:0] o_imm,
   output logic             o_legal
);

   logic [3:0]       w_code;
   logic [3:0]       w_map;
   logic             w_is_imm;
   logic [WIDTH-1:0] w_imm_zext;
   logic [WIDTH-1:0] w_imm_sext;

   // Register forms carry the function in opext, immediate forms in op.
   assign w_is_imm   = (i_op != OP_REG);
   assign w_code     = w_is_imm ? i_op : i_opext;
   assign w_map      = code_to_alucont(w_code);
   assign w_imm_zext = {{(WIDTH-8){1'b0}}, i_imm8};
   assign w_imm_sext = {{(WIDTH-8){i_imm8[7]}}, i_imm8};

   always_comb begin
      o_legal      = w_map[3];
      o_alucont    = w_map[2:0];
      o_alusrc_imm = w_is_imm;
      o_imm        = '0;
      if (w_is_imm) begin
         // Logical immediates are zero-extended, arithmetic ones sign-extended.
         if (w_code == CODE_AND || w_code == CODE_OR)
            o_imm = w_imm_zext;
         else
            o_imm = w_imm_sext;
      end
   end

endmodule

// File: rtl/alu_controller.sv
// ---------------------------------------------------------------------------
// alu_controller
//   Multicycle control FSM for the 16-bit ALU datapath. Accepts one
//   instruction per valid/ready handshake, latches it into IR, then walks
//   DECODE -> EXECUTE -> WRITEBACK and pulses regwrite/done. Undefined
//   encodings leave DECODE straight back to IDLE with an illegal/done pulse.
//   Outputs depend only on state and IR, so nothing combinational runs from
//   i_instr to any output.
// Ports
//   i_clk, i_reset       clock; asynchronous active-low reset
//   i_instr_valid/i_instr  instruction handshake input
//   o_instr_ready        high only in IDLE
//   o_ra1/o_ra2          register-file read addresses (rdest / rsrc)
//   o_alucont            ALU control word
//   o_alusrc_imm/o_imm   b-operand select and extended immediate
//   o_regwrite/o_wa      write-back strobe and address
//   o_done/o_illegal     completion pulses
// ---------------------------------------------------------------------------
module alu_controller
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int RADDR = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_instr_valid,
   input  logic [15:0]      i_instr,
   output logic             o_instr_ready,
   output logic [RADDR-1:0] o_ra1,
   output logic [RADDR-1:0] o_ra2,
   output logic [2:0]       o_alucont,
   output logic             o_alusrc_imm,
   output logic [WIDTH-1:0] o_imm,
   output logic             o_regwrite,
   output logic [RADDR-1:0] o_wa,
   output logic             o_done,
   output logic             o_illegal
);

   state_t           r_state;
   logic [15:0]      r_ir;

   logic [2:0]       w_alucont;
   logic             w_alusrc_imm;
   logic [WIDTH-1:0] w_imm;
   logic             w_legal;
   logic [RADDR-1:0] w_rdest;
   logic [RADDR-1:0] w_rsrc;

   assign w_rdest = RADDR'(r_ir[11:8]);
   assign w_rsrc  = RADDR'(r_ir[3:0]);

   alu_decode #(.WIDTH(WIDTH)) u_decode (
      .i_op         (r_ir[15:12]),
      .i_opext      (r_ir[7:4]),
      .i_imm8       (r_ir[7:0]),
      .o_alucont    (w_alucont),
      .o_alusrc_imm (w_alusrc_imm),
      .o_imm        (w_imm),
      .o_legal      (w_legal)
   );

   // Sequencer. IR only loads in IDLE, so instr is ignored while busy and a
   // held instr_valid yields exactly one accept per IDLE visit.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= IDLE;
         r_ir    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_instr_valid) begin
                  r_ir    <= i_instr;
                  r_state <= DECODE;
               end
            end
            DECODE:    r_state <= w_legal ? EXECUTE : IDLE;
            EXECUTE:   r_state <= WRITEBACK;
            WRITEBACK: r_state <= IDLE;
            default:   r_state <= IDLE;
         endcase
      end
   end

   // Moore output decode. Everything idles at the reset values in IDLE;
   // addresses come up in DECODE and stay put through WRITEBACK, the ALU
   // controls come up in EXECUTE and are held through WRITEBACK.
   always_comb begin
      o_instr_ready = 1'b0;
      o_ra1         = '0;
      o_ra2         = '0;
      o_wa          = '0;
      o_alucont     = '0;
      o_alusrc_imm  = 1'b0;
      o_imm         = '0;
      o_regwrite    = 1'b0;
      o_done        = 1'b0;
      o_illegal     = 1'b0;
      case (r_state)
         IDLE: o_instr_ready = 1'b1;
         DECODE: begin
            o_ra1     = w_rdest;
            o_ra2     = w_rsrc;
            o_wa      = w_rdest;
            o_illegal = !w_legal;
            o_done    = !w_legal;
         end
         EXECUTE, WRITEBACK: begin
            o_ra1        = w_rdest;
            o_ra2        = w_rsrc;
            o_wa         = w_rdest;
            o_alucont    = w_alucont;
            o_alusrc_imm = w_alusrc_imm;
            o_imm        = w_imm;
            // Only legal instructions reach here, so regwrite and illegal
            // can never coincide.
            o_regwrite   = (r_state == WRITEBACK);
            o_done       = (r_state == WRITEBACK);
         end
         default: o_instr_ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_alu_controller.sv
module tb_alu_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        instr_valid = 1'b0;
   logic [15:0] instr = '0;
   logic        instr_ready;
   logic [3:0]  ra1, ra2, wa;
   logic [2:0]  alucont;
   logic        alusrc_imm;
   logic [15:0] imm;
   logic        regwrite, done, illegal;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_controller #(.WIDTH(16), .RADDR(4)) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_instr_valid (instr_valid),
      .i_instr       (instr),
      .o_instr_ready (instr_ready),
      .o_ra1         (ra1),
      .o_ra2         (ra2),
      .o_alucont     (alucont),
      .o_alusrc_imm  (alusrc_imm),
      .o_imm         (imm),
      .o_regwrite    (regwrite),
      .o_wa          (wa),
      .o_done        (done),
      .o_illegal     (illegal)
   );

   typedef struct {
      logic [15:0] instr;
      logic        legal;
      logic [2:0]  alucont;
      logic        alusrc;
      logic [15:0] imm;
      logic [3:0]  ra1;
      logic [3:0]  ra2;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Offers one instruction at an IDLE cycle and follows it to completion.
   task automatic run_vec(input vec_t v);
      @(negedge clk);
      chk("ready_before_accept", 32'(instr_ready), 1);
      instr_valid = 1'b1;
      instr = v.instr;
      @(negedge clk);                      // cycle 1: DECODE
      instr_valid = 1'b0;
      chk("c1_ready", 32'(instr_ready), 0);
      chk("c1_illegal", 32'(illegal), 32'(!v.legal));
      chk("c1_done", 32'(done), 32'(!v.legal));
      chk("c1_regwrite", 32'(regwrite), 0);
      chk("c1_ra1", 32'(ra1), 32'(v.ra1));
      chk("c1_ra2", 32'(ra2), 32'(v.ra2));
      @(negedge clk);                      // cycle 2
      if (v.legal) begin
         chk("c2_alucont", 32'(alucont), 32'(v.alucont));
         chk("c2_alusrc", 32'(alusrc_imm), 32'(v.alusrc));
         chk("c2_imm", 32'(imm), 32'(v.imm));
         chk("c2_regwrite", 32'(regwrite), 0);
         chk("c2_done", 32'(done), 0);
         chk("c2_ready", 32'(instr_ready), 0);
         @(negedge clk);                   // cycle 3
         chk("c3_regwrite", 32'(regwrite), 1);
         chk("c3_done", 32'(done), 1);
         chk("c3_illegal", 32'(illegal), 0);
         chk("c3_wa", 32'(wa), 32'(v.ra1));
         chk("c3_alucont", 32'(alucont), 32'(v.alucont));
         @(negedge clk);                   // cycle 4
         chk("c4_ready", 32'(instr_ready), 1);
         chk("c4_regwrite", 32'(regwrite), 0);
      end else begin
         chk("c2_ready_illegal", 32'(instr_ready), 1);
         chk("c2_regwrite_illegal", 32'(regwrite), 0);
         chk("c2_illegal_clear", 32'(illegal), 0);
      end
   endtask

   initial begin
      //            instr    legal alucont alusrc imm      ra1   ra2
      vecs[0] = '{16'h0351, 1'b1, 3'b010, 1'b0, 16'h0000, 4'h3, 4'h1}; // ADD r3,r1
      vecs[1] = '{16'h92FF, 1'b1, 3'b110, 1'b1, 16'hFFFF, 4'h2, 4'hF}; // SUBI r2,-1
      vecs[2] = '{16'h1480, 1'b1, 3'b000, 1'b1, 16'h0080, 4'h4, 4'h0}; // ANDI r4,0x80
      vecs[3] = '{16'hF000, 1'b0, 3'b000, 1'b0, 16'h0000, 4'h0, 4'h0}; // bad op
      vecs[4] = '{16'h0BB1, 1'b1, 3'b111, 1'b0, 16'h0000, 4'hB, 4'h1}; // SLT r11,r1
      vecs[5] = '{16'h0723, 1'b1, 3'b001, 1'b0, 16'h0000, 4'h7, 4'h3}; // OR r7,r3
      vecs[6] = '{16'h2AF0, 1'b1, 3'b001, 1'b1, 16'h00F0, 4'hA, 4'h0}; // ORI zero-ext
      vecs[7] = '{16'hB380, 1'b1, 3'b111, 1'b1, 16'hFF80, 4'h3, 4'h0}; // SLTI sign-ext
      vecs[8] = '{16'h517F, 1'b1, 3'b010, 1'b1, 16'h007F, 4'h1, 4'hF}; // ADDI +127
      vecs[9] = '{16'h0135, 1'b0, 3'b000, 1'b0, 16'h0000, 4'h1, 4'h5}; // bad opext

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(instr_ready), 1);
      chk("rst_regwrite", 32'(regwrite), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_illegal", 32'(illegal), 0);
      chk("rst_alucont", 32'(alucont), 0);
      chk("rst_alusrc", 32'(alusrc_imm), 0);
      chk("rst_imm", 32'(imm), 0);
      chk("rst_addr", 32'({ra1, ra2, wa}), 0);
      reset = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // instr_valid held high: one accept per IDLE visit, instr ignored while busy
      @(negedge clk);
      instr_valid = 1'b1;
      instr = 16'h0351;
      @(negedge clk);                      // cycle 1
      instr = 16'h0BB1;                    // must not disturb the first instruction
      chk("hold_c1_ready", 32'(instr_ready), 0);
      @(negedge clk);                      // cycle 2
      chk("hold_c2_alucont", 32'(alucont), 3'b010);
      chk("hold_c2_ra1", 32'(ra1), 3);
      @(negedge clk);                      // cycle 3
      chk("hold_c3_regwrite", 32'(regwrite), 1);
      chk("hold_c3_wa", 32'(wa), 3);
      @(negedge clk);                      // cycle 4: IDLE, second accept at this edge
      chk("hold_c4_ready", 32'(instr_ready), 1);
      @(negedge clk);                      // cycle 5
      chk("hold_c5_ready", 32'(instr_ready), 0);
      chk("hold_c5_ra1", 32'(ra1), 4'hB);
      @(negedge clk);                      // cycle 6
      instr_valid = 1'b0;
      chk("hold_c6_alucont", 32'(alucont), 3'b111);
      @(negedge clk);                      // cycle 7
      chk("hold_c7_regwrite", 32'(regwrite), 1);
      chk("hold_c7_wa", 32'(wa), 4'hB);
      @(negedge clk);
      chk("hold_c8_ready", 32'(instr_ready), 1);

      // Reset during EXECUTE aborts the instruction
      instr_valid = 1'b1;
      instr = 16'h0351;
      @(negedge clk);                      // cycle 1
      instr_valid = 1'b0;
      @(negedge clk);                      // cycle 2: EXECUTE
      chk("abort_pre_alucont", 32'(alucont), 3'b010);
      reset = 1'b0;
      #1;
      chk("abort_ready", 32'(instr_ready), 1);
      chk("abort_alucont", 32'(alucont), 0);
      chk("abort_regwrite", 32'(regwrite), 0);
      @(negedge clk);                      // would have been cycle 3
      chk("abort_c3_regwrite", 32'(regwrite), 0);
      chk("abort_c3_done", 32'(done), 0);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_post_regwrite", 32'(regwrite), 0);
      run_vec(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends on its own
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
